// File: rtl/multibyte_add_sequencer_if.sv
// Operand and result handshakes of the multi-byte adder sequencer.
// The master side offers operands and takes results; the slave side is the sequencer.
interface multibyte_add_sequencer_if #(
  parameter int NBYTES = 4
) ();
  localparam int W = 8 * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;

  modport master (
    output in_valid, op_a, op_b, op_cin, out_ready,
    input  in_ready, out_valid, result, carry_out
  );

  modport slave (
    input  in_valid, op_a, op_b, op_cin, out_ready,
    output in_ready, out_valid, result, carry_out
  );
endinterface

// File: rtl/multibyte_add_sequencer.sv
// Byte-serial carry-ripple controller around an external 8-bit adder.
// Operands are taken once, fed LSB byte first, and the full result is handed back.
//
//   state | meaning
//   IDLE  | waiting for an operand set, in_ready high
//   RUN   | driving byte[idx] into the adder, collecting sum/cout each edge
//   DONE  | result and carry_out presented, waiting for out_ready
module multibyte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  multibyte_add_sequencer_if.slave      bus,
  output logic [7:0]                    add_a,
  output logic [7:0]                    add_b,
  output logic                          add_cin,
  input  logic [7:0]                    add_sum,
  input  logic                          add_cout,
  output logic                          busy
);
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state;
  logic [NBYTES-1:0][7:0]   a_reg;
  logic [NBYTES-1:0][7:0]   b_reg;
  logic [NBYTES-1:0][7:0]   result_reg;
  logic                     carry_reg;
  logic                     carry_out_reg;
  logic [IW-1:0]            idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      result_reg    <= '0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
      idx           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg      <= bus.op_a;
            b_reg      <= bus.op_b;
            carry_reg  <= bus.op_cin;
            result_reg <= '0;
            idx        <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          result_reg[idx] <= add_sum;
          carry_reg       <= add_cout;
          idx             <= idx + IW'(1);
          if (idx == LAST_IDX) begin
            carry_out_reg <= add_cout;
            state         <= DONE;
          end
        end
        DONE: begin
          // Handoff edge returns to IDLE only; a new accept needs a further edge.
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Adder inputs come straight from registers so they are stable for the whole cycle.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[idx];
      add_b   = b_reg[idx];
      add_cin = carry_reg;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_reg;
  assign bus.carry_out = carry_out_reg;
  assign busy          = (state != IDLE);
endmodule
